// File: rtl/pwl_pkg.sv
// Shared types for the piecewise-linear activation unit: segment entry, reset entry,
// and the saturating helpers used by the output stage.
package pwl_pkg;

  localparam int PWL_DATA_W  = 16;
  localparam int PWL_SHIFT_W = 4;

  typedef struct packed {
    logic [PWL_DATA_W-1:0]  bp;
    logic [PWL_SHIFT_W-1:0] shift;
    logic                   zero;
    logic [PWL_DATA_W-1:0]  bias;
  } seg_entry_t;

  // Cleared table answers 0 for every input until software programs it.
  localparam seg_entry_t SEG_RESET = '{bp: '0, shift: '0, zero: 1'b1, bias: '0};

  function automatic logic [PWL_DATA_W-1:0] sat_data(input logic signed [PWL_DATA_W+1:0] v);
    logic signed [PWL_DATA_W+1:0] maxv;
    logic signed [PWL_DATA_W+1:0] minv;
    maxv = {3'b000, {(PWL_DATA_W-1){1'b1}}};
    minv = {3'b111, {(PWL_DATA_W-1){1'b0}}};
    if (v > maxv) return maxv[PWL_DATA_W-1:0];
    if (v < minv) return minv[PWL_DATA_W-1:0];
    return v[PWL_DATA_W-1:0];
  endfunction

  function automatic logic [PWL_DATA_W-1:0] neg_sat(input logic [PWL_DATA_W-1:0] v);
    if (v == {1'b1, {(PWL_DATA_W-1){1'b0}}}) return {1'b0, {(PWL_DATA_W-1){1'b1}}};
    return -v;
  endfunction

endpackage

// File: rtl/pwl_seg_select.sv
// Segment index: counts breakpoints bp[1..SEG_N-1] that x meets or exceeds (signed).
// Purely combinational; sits inside the first pipeline stage.
module pwl_seg_select #(
  parameter int DATA_W = 16,
  parameter int SEG_N  = 16,
  parameter int K_W    = $clog2(SEG_N)
) (
  input  logic [DATA_W-1:0]           x,
  input  logic [(SEG_N-1)*DATA_W-1:0] bp_hi,
  output logic [K_W-1:0]              k
);

  logic [SEG_N-2:0] ge;

  for (genvar g = 0; g < SEG_N-1; g++) begin : g_cmp
    assign ge[g] = $signed(x) >= $signed(bp_hi[g*DATA_W +: DATA_W]);
  end

  always_comb begin
    k = '0;
    for (int i = 0; i < SEG_N-1; i++) begin
      k = k + K_W'(ge[i]);
    end
  end

endmodule

// File: rtl/pwl_act_unit.sv
// Pipelined PWL activation y = bias[k] + ((x - bp[k]) >>> shift[k]), 3-cycle latency, global stall on out_ready.
// Optional odd-symmetric mode (table covers x >= 0, sign reapplied at output) via PWL_ODD_SYM_EN.
module pwl_act_unit
  import pwl_pkg::*;
#(
  parameter int DATA_W  = PWL_DATA_W,
  parameter int FRAC_W  = 8,
  parameter int SEG_N   = 16,
  parameter int SHIFT_W = PWL_SHIFT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_y,
  input  logic                     tbl_we,
  input  logic [$clog2(SEG_N)-1:0] tbl_addr,
  input  logic [DATA_W-1:0]        tbl_bp,
  input  logic [SHIFT_W-1:0]       tbl_shift,
  input  logic                     tbl_zero,
  input  logic [DATA_W-1:0]        tbl_bias
);

  localparam int K_W = $clog2(SEG_N);
  localparam logic [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Entry field widths are fixed by pwl_pkg; reject any parameter set that disagrees.
  if (DATA_W != PWL_DATA_W || SHIFT_W != PWL_SHIFT_W || FRAC_W >= DATA_W || SEG_N < 2) begin : g_param_check
    $error("pwl_act_unit: unsupported parameter set");
  end

  seg_entry_t tbl [SEG_N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SEG_N; i++) tbl[i] <= SEG_RESET;
    end else if (tbl_we) begin
      tbl[tbl_addr] <= '{bp: tbl_bp, shift: tbl_shift, zero: tbl_zero, bias: tbl_bias};
    end
  end

  logic adv;
  logic s1_vld, s2_vld, s3_vld;

  assign adv       = !s3_vld || out_ready;
  assign in_ready  = adv;
  assign out_valid = s3_vld;

  logic [DATA_W-1:0] xs;
`ifdef PWL_ODD_SYM_EN
  logic x_neg;
  logic s1_neg, s2_neg;
  assign x_neg = in_x[DATA_W-1];
  always_comb begin
    xs = in_x;
    if (x_neg) xs = (in_x == DMIN) ? DMAX : -in_x;
  end
`else
  assign xs = in_x;
`endif

  logic [(SEG_N-1)*DATA_W-1:0] bp_hi;
  for (genvar g = 1; g < SEG_N; g++) begin : g_bp
    assign bp_hi[(g-1)*DATA_W +: DATA_W] = tbl[g].bp;
  end

  logic [K_W-1:0] k;
  pwl_seg_select #(
    .DATA_W(DATA_W),
    .SEG_N (SEG_N),
    .K_W   (K_W)
  ) u_sel (
    .x    (xs),
    .bp_hi(bp_hi),
    .k    (k)
  );

  seg_entry_t        sel;
  seg_entry_t        s1_ent;
  logic [DATA_W-1:0] s1_x;
  assign sel = tbl[k];

  // Difference is one bit wider so x - bp never wraps before the shift.
  logic signed [DATA_W:0] d;
  logic signed [DATA_W:0] sh;
  logic signed [DATA_W:0] s;
  always_comb begin
    d  = $signed({s1_x[DATA_W-1], s1_x}) - $signed({s1_ent.bp[DATA_W-1], s1_ent.bp});
    sh = d >>> s1_ent.shift;
    s  = s1_ent.zero ? '0 : sh;
  end

  logic [DATA_W:0]          s2_s;
  logic [DATA_W-1:0]        s2_bias;
  logic signed [DATA_W+1:0] r;
  logic [DATA_W-1:0]        y;
  always_comb begin
    r = $signed({s2_s[DATA_W], s2_s}) + $signed({{2{s2_bias[DATA_W-1]}}, s2_bias});
    y = sat_data(r);
`ifdef PWL_ODD_SYM_EN
    if (s2_neg) y = neg_sat(y);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s3_vld  <= 1'b0;
      s1_x    <= '0;
      s1_ent  <= SEG_RESET;
      s2_s    <= '0;
      s2_bias <= '0;
      out_y   <= '0;
`ifdef PWL_ODD_SYM_EN
      s1_neg  <= 1'b0;
      s2_neg  <= 1'b0;
`endif
    end else if (adv) begin
      s1_vld  <= in_valid;
      s2_vld  <= s1_vld;
      s3_vld  <= s2_vld;
      s1_x    <= xs;
      s1_ent  <= sel;
      s2_s    <= s;
      s2_bias <= s1_ent.bias;
      out_y   <= y;
`ifdef PWL_ODD_SYM_EN
      s1_neg  <= x_neg;
      s2_neg  <= s1_neg;
`endif
    end
  end

endmodule

// File: tb/tb_pwl_act_unit.sv
// Scoreboard bench for pwl_act_unit: directed vectors with hand-computed results,
// checked in order by an independent output monitor.
module tb_pwl_act_unit;

`ifdef PWL_ODD_SYM_EN
  localparam bit ODD = 1'b1;
`else
  localparam bit ODD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_y;
  logic        tbl_we = 1'b0;
  logic [3:0]  tbl_addr = '0;
  logic [15:0] tbl_bp = '0;
  logic [3:0]  tbl_shift = '0;
  logic        tbl_zero = 1'b0;
  logic [15:0] tbl_bias = '0;

  pwl_act_unit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .tbl_we   (tbl_we),
    .tbl_addr (tbl_addr),
    .tbl_bp   (tbl_bp),
    .tbl_shift(tbl_shift),
    .tbl_zero (tbl_zero),
    .tbl_bias (tbl_bias)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] y;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %h expected no output", out_y);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_y", {16'h0, out_y}, {16'h0, e.y});
        if (e.lat) chk("latency", cyc - e.cyc, 3);
      end
    end
  end

  task automatic wr(input int a, input logic [15:0] bp, input logic [3:0] sh,
                    input logic z, input logic [15:0] b);
    tbl_we = 1'b1; tbl_addr = a[3:0]; tbl_bp = bp; tbl_shift = sh; tbl_zero = z; tbl_bias = b;
    @(posedge clk); #1;
    tbl_we = 1'b0;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input bit lat);
    int n = 0;
    in_valid = 1'b1;
    in_x = x;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    else exp_q.push_back('{y: y, cyc: cyc, lat: lat});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  logic [15:0] bx [5] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
  logic [15:0] by [5] = '{16'h0100, 16'h0210, 16'h0310, 16'h0410, 16'h0510};

  initial begin
    int idx;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    @(posedge clk); #1;

    // Cleared table gives zero.
    send(16'h0100, 16'h0000, 1);
    drain();

    // Identity segment 0; upper segments parked at 0x7FFF with a flat 0x0040.
    wr(0, 16'h0000, 4'd0, 1'b0, 16'h0000);
    for (int i = 1; i < 16; i++) wr(i, 16'h7FFF, 4'd0, 1'b1, 16'h0040);
    for (int i = 0; i < 8; i++) send(16'h0080 + 16'(i * 16), 16'h0080 + 16'(i * 16), 1);
    drain();

    wr(1, 16'h0118, 4'd1, 1'b0, 16'h0113);
    send(16'h0200, 16'h0187, 1);
    send(16'h0117, 16'h0117, 1);
    send(16'h0118, 16'h0113, 1);
    send(16'h7FFF, 16'h0040, 1);
    send(16'hFE00, ODD ? 16'hFE79 : 16'hFE00, 1);
    send(16'h8000, ODD ? 16'hFFC0 : 16'h8000, 1);
`ifdef PWL_ODD_SYM_EN
    send(16'hFEE9, 16'hFEE9, 1);
`endif
    drain();

    // Saturation at both rails.
    for (int i = 0; i < 16; i++) wr(i, 16'h0000, 4'd0, 1'b0, 16'h7F00);
    send(16'h7FFF, 16'h7FFF, 1);
    send(16'h0000, 16'h7F00, 1);
    for (int i = 0; i < 16; i++) wr(i, 16'h0000, 4'd0, 1'b0, 16'h8100);
    send(16'h8000, ODD ? 16'hFF01 : 16'h8000, 1);
    send(16'h7FFF, 16'h00FF, 1);
    drain();

    // Backpressure with a table write on the first acceptance cycle.
    for (int i = 0; i < 16; i++) wr(i, 16'h0000, 4'd0, 1'b0, 16'h0000);
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    in_x = bx[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) chk("stall_hold_y", out_y, 16'h0100);
      if (in_ready) begin
        exp_q.push_back('{y: by[idx], cyc: cyc, lat: 1'b0});
        if (idx == 0) begin
          tbl_we = 1'b1; tbl_addr = 4'd15; tbl_bp = 16'h0000;
          tbl_shift = 4'd0; tbl_zero = 1'b0; tbl_bias = 16'h0010;
        end
        idx++;
      end
      @(posedge clk); #1;
      tbl_we = 1'b0;
      in_x = bx[idx];
    end
    chk("stall_accepted", idx, 3);
    @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_out_y", out_y, 16'h0100);
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    while (idx < 5 && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{y: by[idx], cyc: cyc, lat: 1'b0});
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 5) in_x = bx[idx];
      n++;
    end
    in_valid = 1'b0;
    chk("release_accepted", idx, 5);
    drain();

    // Reset while a sample is in flight: it must vanish and the table must clear.
    in_valid = 1'b1;
    in_x = 16'h0100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("flush_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    send(16'h0100, 16'h0000, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
